sap1_ctrl_seq: RTL and testbench
================================

Name: sap1_ctrl_seq

Overview:
- SAP-1 controller-sequencer: six-state ring counter (T1–T6) plus instruction decoder.
- Drives the active-high load/enable strobes consumed by the SAP-1 registers: LOAD pins of the buffer/accumulator/B/output/MAR/IR registers, and the bus-enable pins.
- Sits between the instruction register's upper nibble and every register in the datapath.
- Implements fetch (T1–T3) and execute (T4–T6) for LDA, ADD, SUB, OUT, HLT.

Parameters:
OP_LDA, 4'b0000, opcode for load accumulator
OP_ADD, 4'b0001, opcode for add
OP_SUB, 4'b0010, opcode for subtract
OP_OUT, 4'b1110, opcode for output
OP_HLT, 4'b1111, opcode for halt

Ports:
CLK  input  1  system clock, rising-edge active
CLR  input  1  asynchronous active-high reset
OPCODE  input  4  instruction register bits [7:4]
T  output  6  one-hot ring state, T[0]=T1 … T[5]=T6
CP  output  1  program counter increment
EP  output  1  program counter enable to bus
LM  output  1  MAR load
CE  output  1  RAM enable to bus
LI  output  1  IR load
EI  output  1  IR address nibble enable to bus
LA  output  1  accumulator load
EA  output  1  accumulator enable to bus
SU  output  1  ALU subtract select
EU  output  1  ALU enable to bus
LB  output  1  B register load
LO  output  1  output register load
HLT  output  1  halted flag

Behaviour:
- Interface: one clock (CLK); reset CLR is asynchronous and active-high.
- State:
  - Registered one-hot ring T plus registered halt flag.
  - All strobes are combinational decode of (T, OPCODE, halt).
- Reset:
  - CLR=1 forces T=6'b000001 and HLT=0 immediately, with no clock edge needed.
  - The strobes therefore show the T1 pattern (EP=1, LM=1, all others 0).
- Ring advance:
  - Each rising CLK edge with CLR=0 and halt=0: T1→T2→T3→T4→T5→T6→T1 (rotate left, T6 wraps to T1).
  - T is always one-hot; no other encoding is reachable.
- Fetch cycle (opcode-independent):
  - T1: EP, LM.
  - T2: CP.
  - T3: CE, LI.
- Execute cycle:
  - LDA: T4 EI, LM; T5 CE, LA; T6 none.
  - ADD: T4 EI, LM; T5 CE, LB; T6 EU, LA.
  - SUB: T4 EI, LM; T5 CE, LB; T6 EU, SU, LA.
  - OUT: T4 EA, LO; T5 none; T6 none.
  - HLT: T4 none; halt flag is set on the rising edge ending T4.
  - Any undefined opcode: T4–T6 none (NOP); ring continues.
- Halt:
  - Once set, HLT=1, T freezes at T4 and all strobes read 0 regardless of OPCODE.
  - Only CLR leaves halt.
- OPCODE timing:
  - Sampled combinationally.
  - Must be stable from T4 through T6 (IR loads at the end of T3).
  - Values during T1–T3 are ignored.
- Strobe sets:
  - At most one bus-enable strobe (EP, CE, EI, EA, EU) is high in any state.
  - Strobes not listed for a state are 0.
- Reset mid-instruction: CLR in any state (including halted) aborts the instruction and returns to T1 with HLT=0 asynchronously.
- Release of CLR: the first rising edge after deassertion moves T1→T2.

Test Plan:
- Reset: assert CLR mid-T5 → T=000001, HLT=0, EP=1, LM=1, all other strobes 0, before the next CLK edge.
- Fetch/wrap: OPCODE=4'b0000, 7 edges after reset → T sequence 000010, 000100, 001000, 010000, 100000, 000001, 000010; T2 CP=1 only; T3 CE=1, LI=1.
- ADD vs SUB: OPCODE=4'b0001 → T6 EU=1, LA=1, SU=0. OPCODE=4'b0010 → T6 EU=1, LA=1, SU=1. Both: T5 CE=1, LB=1.
- OUT and undefined: OPCODE=4'b1110 → T4 EA=1, LO=1, T5/T6 all 0. OPCODE=4'b0111 → T4–T6 all strobes 0, ring keeps cycling.
- Halt: OPCODE=4'b1111 → after the edge ending T4, HLT=1, T holds 001000 for 10 further edges, all strobes 0. Then pulse CLR → T=000001, HLT=0.
- One-hot/bus check: random opcodes for 200 cycles → popcount(T)=1 and at most one of EP/CE/EI/EA/EU high on every cycle.

Source files
------------

// File: rtl/sap1_ctrl_seq.sv
// SAP-1 controller-sequencer: six-state one-hot ring (T1..T6) with a halt flag.
// Every strobe is a combinational decode of the ring state, OPCODE and halt.
module sap1_ctrl_seq #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] OPCODE,
  output logic [5:0] T,
  output logic       CP,
  output logic       EP,
  output logic       LM,
  output logic       CE,
  output logic       LI,
  output logic       EI,
  output logic       LA,
  output logic       EA,
  output logic       SU,
  output logic       EU,
  output logic       LB,
  output logic       LO,
  output logic       HLT
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_e;

  ring_e state_q, state_d;
  logic  halt_q, halt_d;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= T1;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    CP = 1'b0; EP = 1'b0; LM = 1'b0; CE = 1'b0; LI = 1'b0; EI = 1'b0;
    LA = 1'b0; EA = 1'b0; SU = 1'b0; EU = 1'b0; LB = 1'b0; LO = 1'b0;
    if (!halt_q) begin
      case (state_q)
        T1: begin
          state_d = T2;
          EP = 1'b1;
          LM = 1'b1;
        end
        T2: begin
          state_d = T3;
          CP = 1'b1;
        end
        T3: begin
          state_d = T4;
          CE = 1'b1;
          LI = 1'b1;
        end
        T4: begin
          state_d = T5;
          case (OPCODE)
            OP_LDA, OP_ADD, OP_SUB: begin
              EI = 1'b1;
              LM = 1'b1;
            end
            OP_OUT: begin
              EA = 1'b1;
              LO = 1'b1;
            end
            // Ring stays parked on T4 once halted.
            OP_HLT: begin
              state_d = T4;
              halt_d  = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          state_d = T6;
          case (OPCODE)
            OP_LDA: begin
              CE = 1'b1;
              LA = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              CE = 1'b1;
              LB = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          state_d = T1;
          case (OPCODE)
            OP_ADD: begin
              EU = 1'b1;
              LA = 1'b1;
            end
            OP_SUB: begin
              EU = 1'b1;
              SU = 1'b1;
              LA = 1'b1;
            end
            default: ;
          endcase
        end
        default: state_d = T1;
      endcase
    end
  end

  assign T   = state_q;
  assign HLT = halt_q;

endmodule

// File: tb/tb_sap1_ctrl_seq.sv
// Bench for sap1_ctrl_seq: directed steps then random opcodes, checked against
// a step-index/halt-flag reference model of the SAP-1 instruction table.
module tb_sap1_ctrl_seq;

  logic       CLK, CLR;
  logic [3:0] OPCODE;
  logic [5:0] T;
  logic CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO, HLT;

  int checks = 0;
  int failures = 0;

  // model: step 0..5 means T1..T6
  int model_step;
  bit model_halt;

  localparam logic [11:0] M_CP = 12'h800, M_EP = 12'h400, M_LM = 12'h200,
                          M_CE = 12'h100, M_LI = 12'h080, M_EI = 12'h040,
                          M_LA = 12'h020, M_EA = 12'h010, M_SU = 12'h008,
                          M_EU = 12'h004, M_LB = 12'h002, M_LO = 12'h001;

  sap1_ctrl_seq dut (
    .CLK(CLK), .CLR(CLR), .OPCODE(OPCODE), .T(T),
    .CP(CP), .EP(EP), .LM(LM), .CE(CE), .LI(LI), .EI(EI),
    .LA(LA), .EA(EA), .SU(SU), .EU(EU), .LB(LB), .LO(LO), .HLT(HLT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [11:0] exp_strobes(int step, logic [3:0] op, bit halted);
    if (halted) return 12'h000;
    case (step)
      0: return M_EP | M_LM;
      1: return M_CP;
      2: return M_CE | M_LI;
      3: begin
        if (op == 4'h0 || op == 4'h1 || op == 4'h2) return M_EI | M_LM;
        if (op == 4'hE) return M_EA | M_LO;
        return 12'h000;
      end
      4: begin
        if (op == 4'h0) return M_CE | M_LA;
        if (op == 4'h1 || op == 4'h2) return M_CE | M_LB;
        return 12'h000;
      end
      5: begin
        if (op == 4'h1) return M_EU | M_LA;
        if (op == 4'h2) return M_EU | M_SU | M_LA;
        return 12'h000;
      end
      default: return 12'h000;
    endcase
  endfunction

  task automatic check_all(input string tag);
    logic [11:0] obs_s, exp_s;
    logic [5:0]  exp_t;
    obs_s = {CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO};
    exp_s = exp_strobes(model_step, OPCODE, model_halt);
    exp_t = 6'b000001 << model_step;
    checks++;
    assert (T === exp_t) else begin
      failures++;
      $error("FAIL %s.T observed=%b expected=%b", tag, T, exp_t);
    end
    checks++;
    assert (HLT === model_halt) else begin
      failures++;
      $error("FAIL %s.HLT observed=%b expected=%b", tag, HLT, model_halt);
    end
    checks++;
    assert (obs_s === exp_s) else begin
      failures++;
      $error("FAIL %s.strobes observed=%h expected=%h (op=%h step=%0d)",
             tag, obs_s, exp_s, OPCODE, model_step);
    end
    checks++;
    assert ($countones(T) == 1) else begin
      failures++;
      $error("FAIL %s.onehot observed=%b expected=one bit set", tag, T);
    end
    checks++;
    assert ($countones({EP, CE, EI, EA, EU}) <= 1) else begin
      failures++;
      $error("FAIL %s.bus observed=%b expected=at most one enable", tag,
             {EP, CE, EI, EA, EU});
    end
  endtask

  // one clock edge, model update, check 1ns later
  task automatic clk_step(input string tag);
    @(posedge CLK);
    if (!model_halt) begin
      if (model_step == 3 && OPCODE == 4'hF) model_halt = 1'b1;
      else model_step = (model_step + 1) % 6;
    end
    #1;
    check_all(tag);
  endtask

  // asynchronous clear pulse between edges
  task automatic pulse_clr(input string tag);
    CLR = 1'b1;
    #1;
    model_step = 0;
    model_halt = 1'b0;
    check_all(tag);
    #1;
    CLR = 1'b0;
  endtask

  // advance until the ring sits at T1 (bounded)
  task automatic goto_t1(input string tag);
    for (int i = 0; i < 6 && model_step != 0; i++) clk_step(tag);
  endtask

  task automatic run_instr(input logic [3:0] op, input string tag);
    goto_t1(tag);
    OPCODE = op;
    for (int i = 0; i < 6; i++) clk_step(tag);
  endtask

  initial begin
    logic [3:0] r_op;
    int halted_cycles;
    CLR = 1'b1;
    OPCODE = 4'h0;
    model_step = 0;
    model_halt = 1'b0;
    #2;
    check_all("reset");
    #1;
    CLR = 1'b0;

    // fetch and wrap with LDA
    for (int i = 0; i < 7; i++) clk_step("fetch_wrap");

    run_instr(4'h0, "lda");
    run_instr(4'h1, "add");
    run_instr(4'h2, "sub");
    run_instr(4'hE, "out");
    run_instr(4'h7, "undef");
    run_instr(4'h7, "undef2");

    // clear mid-T5
    goto_t1("pre_clr");
    OPCODE = 4'h1;
    for (int i = 0; i < 4; i++) clk_step("to_t5");
    pulse_clr("clr_mid_t5");
    clk_step("clr_release");

    // halt
    goto_t1("pre_hlt");
    OPCODE = 4'hF;
    for (int i = 0; i < 3; i++) clk_step("hlt_fetch");
    clk_step("hlt_set");
    for (int i = 0; i < 10; i++) begin
      OPCODE = 4'($urandom);
      #1;
      check_all("hlt_hold_op");
      clk_step("hlt_hold");
    end
    pulse_clr("hlt_clr");
    OPCODE = 4'h0;
    clk_step("hlt_release");

    // random opcodes, new one chosen while at T1
    halted_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      if (model_halt) begin
        halted_cycles++;
        if (halted_cycles > 3) begin
          pulse_clr("rand_clr");
          halted_cycles = 0;
        end
      end
      if (model_step == 0 && !model_halt) begin
        case ($urandom_range(0, 5))
          0: r_op = 4'h0;
          1: r_op = 4'h1;
          2: r_op = 4'h2;
          3: r_op = 4'hE;
          4: r_op = 4'hF;
          default: r_op = 4'($urandom);
        endcase
        OPCODE = r_op;
      end
      clk_step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
